// File: rtl/recoded_fp_store_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : recoded_fp_store_arbiter
//  Description : Round-robin arbiter that shares one recoded-to-IEEE float
//                converter between NREQ requesters. The datapath is a two-stage
//                valid/ready pipeline: an input register, then the combinational
//                conversion, then an output register.
//  Revision    : 1.0  initial release
// ============================================================================
module recoded_fp_store_arbiter #(
    parameter int EXP_SIZE = 8,
    parameter int SIG_SIZE = 24,
    parameter int NREQ     = 2
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NREQ-1:0]                     req_valid,
    output logic [NREQ-1:0]                     req_ready,
    input  logic [NREQ*(EXP_SIZE+SIG_SIZE+1)-1:0] req_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [EXP_SIZE+SIG_SIZE-1:0]        out_data,
    output logic [$clog2(NREQ)-1:0]             out_src,
    output logic                                busy,
    output logic [15:0]                         done_count
);

    localparam int SIZE  = EXP_SIZE + SIG_SIZE;
    localparam int SRC_W = $clog2(NREQ);

    // Smallest recoded exponent that still encodes a normal number.
    localparam logic [EXP_SIZE:0]  c_MIN_NORM_EXP = (EXP_SIZE+1)'((1 << (EXP_SIZE-1)) + 2);
    // Offset between the recoded and the IEEE biased exponent.
    localparam logic [EXP_SIZE:0]  c_EXP_OFFSET   = (EXP_SIZE+1)'((1 << (EXP_SIZE-1)) + 1);
    localparam logic [SRC_W:0]     c_NREQ_EXT     = (SRC_W+1)'(NREQ);
    localparam logic [SRC_W-1:0]   c_LAST_REQ     = SRC_W'(NREQ-1);

    // Pipeline registers
    logic                r_s1Valid;
    logic [SIZE:0]       r_s1Data;
    logic [SRC_W-1:0]    r_s1Src;
    logic                r_outValid;
    logic [SIZE-1:0]     r_outData;
    logic [SRC_W-1:0]    r_outSrc;
    logic [SRC_W-1:0]    r_rrPtr;
    logic [15:0]         r_doneCount;

    // Control and arbitration wires
    logic                w_s2Free;
    logic                w_s1Adv;
    logic                w_s1Free;
    logic                w_found;
    logic                w_grant;
    logic [SRC_W-1:0]    w_grantIdx;
    logic [SRC_W:0]      w_sum;
    logic [SRC_W-1:0]    w_cand;
    logic [SIZE:0]       w_grantData;
    logic                w_outAccept;

    // Conversion wires
    logic                w_sign;
    logic [EXP_SIZE:0]   w_expIn;
    logic [SIG_SIZE-2:0] w_fract;
    logic [2:0]          w_expTop;
    logic [EXP_SIZE:0]   w_shiftDist;
    logic [SIG_SIZE-2:0] w_subFract;
    logic [SIZE-1:0]     w_conv;

    assign w_s2Free    = ~r_outValid | out_ready;
    assign w_s1Adv     = r_s1Valid & w_s2Free;
    assign w_s1Free    = ~r_s1Valid | w_s2Free;
    assign w_outAccept = r_outValid & out_ready;

    // Circular search for the first valid requester starting at the rr pointer.
    always_comb begin
        w_found    = 1'b0;
        w_grantIdx = '0;
        w_sum      = '0;
        w_cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_rrPtr} + (SRC_W+1)'(k);
            if (w_sum >= c_NREQ_EXT) begin
                w_sum = w_sum - c_NREQ_EXT;
            end
            w_cand = w_sum[SRC_W-1:0];
            if (!w_found && req_valid[w_cand]) begin
                w_found    = 1'b1;
                w_grantIdx = w_cand;
            end
        end
    end

    // The reset gate keeps req_ready low while the pipeline is held in reset.
    assign w_grant     = w_found & w_s1Free & reset_n;
    assign w_grantData = req_data[w_grantIdx*(SIZE+1) +: SIZE+1];
    assign req_ready   = w_grant ? (NREQ'(1) << w_grantIdx) : '0;

    // Recoded-to-IEEE conversion of the stage-1 operand.
    assign w_sign      = r_s1Data[SIZE];
    assign w_expIn     = r_s1Data[SIZE-1 -: EXP_SIZE+1];
    assign w_fract     = r_s1Data[SIG_SIZE-2:0];
    assign w_expTop    = w_expIn[EXP_SIZE -: 3];
    assign w_shiftDist = c_MIN_NORM_EXP - w_expIn;
    assign w_subFract  = (SIG_SIZE-1)'({1'b1, w_fract} >> w_shiftDist);

    // Classify the operand and assemble the IEEE encoding.
    always_comb begin
        w_conv = '0;
        if (w_expTop == 3'b000) begin
            w_conv = {w_sign, {(SIZE-1){1'b0}}};
        end else if (w_expTop == 3'b110) begin
            w_conv = {w_sign, {EXP_SIZE{1'b1}}, {(SIG_SIZE-1){1'b0}}};
        end else if (w_expTop == 3'b111) begin
            // NaN payload passes through untouched.
            w_conv = {w_sign, {EXP_SIZE{1'b1}}, w_fract};
        end else if (w_expIn < c_MIN_NORM_EXP) begin
            w_conv = {w_sign, {EXP_SIZE{1'b0}}, w_subFract};
        end else begin
            w_conv = {w_sign, EXP_SIZE'(w_expIn - c_EXP_OFFSET), w_fract};
        end
    end

    // Stage 1 input register and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1Valid <= 1'b0;
            r_s1Data  <= '0;
            r_s1Src   <= '0;
            r_rrPtr   <= '0;
        end else if (w_grant) begin
            r_s1Valid <= 1'b1;
            r_s1Data  <= w_grantData;
            r_s1Src   <= w_grantIdx;
            r_rrPtr   <= (w_grantIdx == c_LAST_REQ) ? '0 : w_grantIdx + SRC_W'(1);
        end else if (w_s1Adv) begin
            r_s1Valid <= 1'b0;
        end
    end

    // Stage 2 output register; data only changes when empty or on a handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outSrc   <= '0;
        end else if (w_s1Adv) begin
            r_outValid <= 1'b1;
            r_outData  <= w_conv;
            r_outSrc   <= r_s1Src;
        end else if (w_outAccept) begin
            r_outValid <= 1'b0;
        end
    end

    // Saturating count of completed output handshakes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_doneCount <= '0;
        end else if (w_outAccept && (r_doneCount != 16'hFFFF)) begin
            r_doneCount <= r_doneCount + 16'd1;
        end
    end

    assign out_valid  = r_outValid;
    assign out_data   = r_outData;
    assign out_src    = r_outSrc;
    assign busy       = r_s1Valid | r_outValid;
    assign done_count = r_doneCount;

endmodule
`default_nettype wire
